ccr_cond_eval: RTL

- Consumer end of the CVNZ condition-code interface produced by the sum/ALU blocks.
- Holds the architectural CCR register, written by the ALU.
- Evaluates 4-bit branch/predicate condition queries against that register, through a valid/ready request/response handshake with a one-entry output buffer.
- Feeds the sequencer's branch decision; also keeps a saturating count of taken conditions for debug.

---
 rtl/ccr_pkg.sv | 41 ++++
 rtl/ccr_cond_decode.sv | 51 +++++
 rtl/ccr_cond_eval.sv | 93 +++++++++
 3 files changed

// File: rtl/ccr_pkg.sv
// ccr_pkg: shared definitions for the CVNZ condition-code interface.
//   - flag bit positions and single-bit masks within the 4-bit CCR {C,V,N,Z}
//   - 4-bit branch/predicate condition codes EQ..NV
//   - response-buffer state encoding used by ccr_cond_eval
package ccr_pkg;

  localparam int C_IDX = 3;
  localparam int V_IDX = 2;
  localparam int N_IDX = 1;
  localparam int Z_IDX = 0;

  localparam logic [3:0] C_MASK = 4'b1000;
  localparam logic [3:0] V_MASK = 4'b0100;
  localparam logic [3:0] N_MASK = 4'b0010;
  localparam logic [3:0] Z_MASK = 4'b0001;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/ccr_cond_decode.sv
// ccr_cond_decode: purely combinational condition evaluator.
//   cond  in  4  condition code (cond_e encoding)
//   ccr   in  4  condition-code register holding C, V, N, Z flags
//   taken out 1  1 when cond holds for the given flags
// Also used standalone by the sequencer's predicated-execution path.
module ccr_cond_decode
  import ccr_pkg::*;
#(
  parameter int C_BIT = C_IDX,
  parameter int V_BIT = V_IDX,
  parameter int N_BIT = N_IDX,
  parameter int Z_BIT = Z_IDX
) (
  input  logic [3:0] cond,
  input  logic [3:0] ccr,
  output logic       taken
);

  logic c, v, n, z;

  assign c = ccr[C_BIT];
  assign v = ccr[V_BIT];
  assign n = ccr[N_BIT];
  assign z = ccr[Z_BIT];

  always_comb begin
    // NOTE: assign a default before the case so every path drives the
    // output; a missed path would otherwise infer a latch.
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ccr_cond_eval.sv
// ccr_cond_eval: architectural CCR register plus condition-query responder.
//   clk, rst       clock; synchronous active-high reset
//   ccr_in/ccr_we  CCR {C,V,N,Z} from the ALU and its write enable
//   req_*          condition query (valid/ready), cond in cond_e encoding
//   rsp_*          one-entry response buffer (valid/ready) with the result
//   ccr_q          current registered CCR
//   taken_cnt      saturating count of accepted queries that evaluated true
// A query accepted alongside ccr_we sees ccr_in (forwarded), so a branch
// right behind a flag-setting op never reads stale flags.
module ccr_cond_eval
  import ccr_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int C_BIT = C_IDX,
  parameter int V_BIT = V_IDX,
  parameter int N_BIT = N_IDX,
  parameter int Z_BIT = Z_IDX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ccr_in,
  input  logic             ccr_we,
  input  logic             req_valid,
  input  logic [3:0]       req_cond,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic             rsp_taken,
  input  logic             rsp_ready,
  output logic [3:0]       ccr_q,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e     state_q, state_d;
  logic [3:0] eval_ccr;
  logic       eval_taken;
  logic       accept;

  assign eval_ccr = ccr_we ? ccr_in : ccr_q;

  ccr_cond_decode #(
    .C_BIT(C_BIT),
    .V_BIT(V_BIT),
    .N_BIT(N_BIT),
    .Z_BIT(Z_BIT)
  ) u_decode (
    .cond (req_cond),
    .ccr  (eval_ccr),
    .taken(eval_taken)
  );

  // req_ready depends only on state and rsp_ready, never on req_valid, so
  // upstream may compute req_valid from req_ready without a comb loop.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (req_valid) state_d = ST_FULL;
      end
      ST_FULL: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready && !req_valid) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign accept = req_valid && req_ready;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      ccr_q     <= 4'b0000;
      rsp_taken <= 1'b0;
      taken_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (ccr_we) ccr_q <= ccr_in;
      // Only an accept overwrites the buffer, so a stalled result stays
      // stable even if the CCR is rewritten underneath it.
      if (accept) rsp_taken <= eval_taken;
      if (accept && eval_taken && (taken_cnt != CNT_MAX))
        taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule
